ps2_rx_frame: RTL and testbench

PS/2 device-to-host frame receiver on the system's input side; the system output register sits on the opposite side.
- Synchronizes and glitch-filters the raw ps2_clk/ps2_data lines.
- Deserializes 11-bit frames (start, 8 data LSB-first, odd parity, stop).
- Presents each received byte with a one-cycle valid strobe to the combinational decode logic.
- Flags parity, framing and timeout errors.

---
 rtl/ps2_rx_frame.sv | 147 ++++++++++++++
 tb/tb_ps2_rx_frame.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host receiver: synchronizes and filters the raw lines, deserializes
// start/8 data/odd parity/stop frames, and pulses rx_valid or rx_err once per frame.
module ps2_rx_frame #(
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned TO_W           = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rx_en,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err,
  output logic       busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  localparam int unsigned FW = 4;
  localparam logic [FW-1:0]   FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [FW-1:0]   FILT_ONE  = FW'(1);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_ONE    = TO_W'(1);

  logic          clk_meta, clk_sync, data_meta, data_sync;
  logic [FW-1:0] filt_cnt;
  logic          clk_filt, clk_filt_prev, fall;

  // Everything resets high so releasing reset never looks like a falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_meta      <= 1'b1;
      clk_sync      <= 1'b1;
      data_meta     <= 1'b1;
      data_sync     <= 1'b1;
      filt_cnt      <= '0;
      clk_filt      <= 1'b1;
      clk_filt_prev <= 1'b1;
      fall          <= 1'b0;
    end else begin
      clk_meta      <= ps2_clk;
      clk_sync      <= clk_meta;
      data_meta     <= ps2_data;
      data_sync     <= data_meta;
      if (clk_sync != clk_filt) begin
        if (filt_cnt == FILT_LAST) begin
          clk_filt <= clk_sync;
          filt_cnt <= '0;
        end else begin
          filt_cnt <= filt_cnt + FILT_ONE;
        end
      end else begin
        filt_cnt <= '0;
      end
      clk_filt_prev <= clk_filt;
      fall          <= clk_filt_prev & ~clk_filt;
    end
  end

  logic [1:0]      state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]      rx_data_d;
  logic            valid_d, err_d;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    to_cnt_d  = to_cnt_q;
    rx_data_d = rx_data;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    if (state_q == IDLE) begin
      to_cnt_d = '0;
      if (fall && rx_en && !data_sync) begin
        state_d   = DATA;
        bit_cnt_d = '0;
        shift_d   = '0;
      end
    end else if (fall) begin
      to_cnt_d = '0;
      case (state_q)
        DATA: begin
          shift_d   = {data_sync, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = data_sync;
          state_d = STOP;
        end
        STOP: begin
          if (data_sync && (^{shift_q, par_q})) begin
            rx_data_d = shift_q;
            valid_d   = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = IDLE;
        end
        default: ;
      endcase
    end else if (to_cnt_q == TO_LAST) begin
      err_d     = 1'b1;
      state_d   = IDLE;
      shift_d   = '0;
      bit_cnt_d = '0;
      to_cnt_d  = '0;
    end else begin
      to_cnt_d = to_cnt_q + TO_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      to_cnt_q  <= '0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      rx_err    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      to_cnt_q  <= to_cnt_d;
      rx_data   <= rx_data_d;
      rx_valid  <= valid_d;
      rx_err    <= err_d;
      busy      <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Directed bench for ps2_rx_frame: good frames, parity/stop/timeout errors, glitches,
// rx_en gating and mid-frame reset. PS/2 bit period is scaled to 80 clk cycles.
module tb_ps2_rx_frame;

  localparam int unsigned HALF = 40;

  logic       clk = 1'b0;
  logic       rst, ps2_clk, ps2_data, rx_en;
  logic [7:0] rx_data;
  logic       rx_valid, rx_err, busy;

  ps2_rx_frame #(
    .FILTER_LEN    (4),
    .TIMEOUT_CYCLES(200),
    .TO_W          (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .rx_en   (rx_en),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .rx_err  (rx_err),
    .busy    (busy)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_valid = 0, n_err = 0, n_both = 0, n_busy = 0, err_cyc = 0;
  always @(negedge clk) begin
    if (rx_valid) n_valid++;
    if (rx_err) begin
      n_err++;
      err_cyc = cyc;
    end
    if (rx_valid && rx_err) n_both++;
    if (busy) n_busy++;
  end

  int n_vec = 0, n_miss = 0;
  int v0, e0, b0;
  int last_fall;
  logic mid_busy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    v0 = n_valid;
    e0 = n_err;
    b0 = n_busy;
  endtask

  // Sends the first nbits bits of {stop, parity, byte, start}, LSB first.
  task automatic send_frame(input logic [7:0] b, input logic par, input logic stp,
                            input int nbits);
    logic [10:0] f;
    f = {stp, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk) ps2_data = f[i];
      repeat (HALF) @(negedge clk);
      ps2_clk   = 1'b0;
      last_fall = cyc;
      repeat (HALF) @(negedge clk);
      if (i == 5) mid_busy = busy;
      ps2_clk = 1'b1;
    end
    @(negedge clk) ps2_data = 1'b1;
  endtask

  initial begin
    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; rx_en = 1'b1; mid_busy = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_data", {24'h0, rx_data}, 32'h00);
    check("rst_valid", {31'h0, rx_valid}, 32'h0);
    check("rst_err", {31'h0, rx_err}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // 0x1C has three ones, so odd parity bit is 0.
    snap();
    send_frame(8'h1C, 1'b0, 1'b1, 11);
    repeat (20) @(negedge clk);
    check("f1c_data", {24'h0, rx_data}, 32'h1C);
    check("f1c_valid", n_valid - v0, 1);
    check("f1c_err", n_err - e0, 0);
    check("f1c_midbusy", {31'h0, mid_busy}, 32'h1);
    check("f1c_busy_end", {31'h0, busy}, 32'h0);

    snap();
    send_frame(8'hF0, 1'b1, 1'b1, 11);
    repeat (20) @(negedge clk);
    check("ff0_data", {24'h0, rx_data}, 32'hF0);
    repeat (180) @(negedge clk);
    send_frame(8'h1C, 1'b0, 1'b1, 11);
    repeat (20) @(negedge clk);
    check("b2b_data", {24'h0, rx_data}, 32'h1C);
    check("b2b_valid", n_valid - v0, 2);
    check("b2b_err", n_err - e0, 0);

    snap();
    send_frame(8'h1C, 1'b1, 1'b1, 11);
    repeat (20) @(negedge clk);
    check("par_err", n_err - e0, 1);
    check("par_valid", n_valid - v0, 0);
    check("par_data", {24'h0, rx_data}, 32'h1C);

    snap();
    send_frame(8'h1C, 1'b0, 1'b0, 11);
    repeat (20) @(negedge clk);
    check("stop_err", n_err - e0, 1);
    check("stop_valid", n_valid - v0, 0);
    check("stop_data", {24'h0, rx_data}, 32'h1C);

    // Start plus four data bits, then the clock line stays high.
    snap();
    send_frame(8'h0F, 1'b1, 1'b1, 5);
    repeat (300) @(negedge clk);
    check("to_err", n_err - e0, 1);
    check("to_valid", n_valid - v0, 0);
    check("to_lat", {31'h0, ((err_cyc - last_fall) >= 200) && ((err_cyc - last_fall) <= 216)},
          32'h1);
    check("to_busy", {31'h0, busy}, 32'h0);
    snap();
    send_frame(8'h5A, 1'b1, 1'b1, 11);
    repeat (20) @(negedge clk);
    check("f5a_data", {24'h0, rx_data}, 32'h5A);
    check("f5a_valid", n_valid - v0, 1);
    check("f5a_err", n_err - e0, 0);

    // Low glitch one sample shorter than the filter length.
    snap();
    @(negedge clk) ps2_data = 1'b0;
    repeat (5) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (3) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (50) @(negedge clk);
    ps2_data = 1'b1;
    repeat (10) @(negedge clk);
    check("glitch_busy", n_busy - b0, 0);
    check("glitch_pulses", (n_valid - v0) + (n_err - e0), 0);

    snap();
    rx_en = 1'b0;
    send_frame(8'h3C, 1'b1, 1'b1, 11);
    repeat (20) @(negedge clk);
    rx_en = 1'b1;
    check("dis_valid", n_valid - v0, 0);
    check("dis_err", n_err - e0, 0);
    check("dis_busy", n_busy - b0, 0);
    check("dis_data", {24'h0, rx_data}, 32'h5A);

    snap();
    send_frame(8'hA5, 1'b1, 1'b1, 6);
    @(negedge clk) rst = 1'b1;
    repeat (3) @(negedge clk);
    check("mrst_data", {24'h0, rx_data}, 32'h00);
    check("mrst_busy", {31'h0, busy}, 32'h0);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    check("mrst_err", n_err - e0, 0);
    check("mrst_valid", n_valid - v0, 0);
    check("mrst_idle", {31'h0, busy}, 32'h0);
    snap();
    send_frame(8'h3C, 1'b1, 1'b1, 11);
    repeat (20) @(negedge clk);
    check("f3c_data", {24'h0, rx_data}, 32'h3C);
    check("f3c_valid", n_valid - v0, 1);
    check("f3c_err", n_err - e0, 0);

    check("never_both", n_both, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
